// File: rtl/ascii_uart_tx_if.sv
// ascii_uart_tx_if
//   Groups the character-in / UART-out signals of ascii_uart_tx.
//   master : character producer and line observer (decoder side / bench)
//   slave  : the transmitter itself
//
//   ascii_in     8        decoded character
//   ascii_valid  1        one-cycle write strobe
//   clr          1        synchronous flush of queue and overflow flag
//   tx           1        UART serial line, idle high
//   busy         1        frame on the line
//   fifo_count   ADDR_W+1 characters queued (excluding the one being sent)
//   fifo_full    1        queue full
//   fifo_empty   1        queue empty
//   overflow     1        sticky: a valid character was dropped
interface ascii_uart_tx_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      ascii_in;
    logic            ascii_valid;
    logic            clr;
    logic            tx;
    logic            busy;
    logic [ADDR_W:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            overflow;

    modport master (
        output ascii_in, ascii_valid, clr,
        input  tx, busy, fifo_count, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  ascii_in, ascii_valid, clr,
        output tx, busy, fifo_count, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx
//   Queues decoded ASCII characters in a small FIFO and sends each one as an
//   8N1 UART frame (start bit, 8 data bits LSB first, stop bit). Consecutive
//   frames follow each other with no idle gap while the queue holds data.
//
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset; forces tx high at once
//   bus   ascii_uart_tx_if.slave (character input, line and queue status)
//
// FSM states:
//   state | meaning
//   IDLE  | line idle (tx = 1), waiting for a queued character
//   START | start bit (tx = 0) for CLKS_PER_BIT cycles
//   DATA  | data bits, shift[0] on the line, LSB first
//   STOP  | stop bit (tx = 1); at its end chain straight into the next frame
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int ADDR_W       = 4
) (
    input logic           clk,
    input logic           rst,
    ascii_uart_tx_if.slave bus
);

    localparam int                DEPTH      = 1 << ADDR_W;
    localparam int                BCNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [BCNT_W-1:0] bcnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              tx_r;
    logic              busy_r;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow_r;

    logic              bit_end;
    logic              full;
    logic              empty;
    logic              pop;
    logic              wr_req;
    logic              wr_en;

    assign bit_end = (bcnt == BCNT_LAST);
    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);

    // The head leaves the queue either from IDLE or on the last cycle of a
    // stop bit. A flush on the same edge suppresses the pop.
    assign pop = !bus.clr && !empty &&
                 ((state == IDLE) || ((state == STOP) && bit_end));

    // 8'h00 is the decoder's "no match" code and never enters the queue.
    assign wr_req = bus.ascii_valid && (bus.ascii_in != 8'h00) && !bus.clr;
    // A same-edge pop frees the slot, so a full queue can still accept.
    assign wr_en  = wr_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.ascii_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            if (wr_req && !wr_en) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // tx and busy are registered and always assigned together with the
    // state they belong to, so the line level changes on the same edge as
    // the state and never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bcnt    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        state  <= START;
                        bcnt   <= '0;
                        tx_r   <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bcnt    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_r    <= shift[0];
                    end else begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bcnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx_r    <= shift[1];
                        end
                    end else begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bcnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx_r  <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tx_r   <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx         = tx_r;
    assign bus.busy       = busy_r;
    assign bus.fifo_count = count;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb_ascii_uart_tx
//   Drives ascii_uart_tx (CLKS_PER_BIT=4, ADDR_W=2) with directed scenarios
//   and randomized character traffic. A transaction-level reference model
//   (queue of characters plus the time left in the current frame) predicts
//   the line level and queue status for every cycle.
module tb_ascii_uart_tx;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ascii_uart_tx_if #(.ADDR_W(AW)) bus ();

    ascii_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: characters waiting, the character on the line, and
    // how many cycles of its frame remain after the latest edge.
    int mq[$];
    int left;
    int cur;
    bit movf;

    int hist_tx[$];
    int hist_busy[$];
    int peak;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        left = 0;
        cur  = 0;
        movf = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit c);
        bit do_pop;
        bit wr_req;
        bit wr_ok;
        do_pop = 1'b0;
        if (left > 0) left--;
        if (left == 0 && mq.size() > 0 && !c) do_pop = 1'b1;
        wr_req = v && (d != 8'h00) && !c;
        wr_ok  = wr_req && (mq.size() < DEPTH || do_pop);
        if (do_pop) begin
            cur  = mq.pop_front();
            left = FRAME;
        end
        if (wr_ok) mq.push_back(int'(d));
        if (wr_req && !wr_ok) movf = 1'b1;
        if (c) begin
            mq.delete();
            movf = 1'b0;
        end
    endtask

    function automatic logic model_tx();
        int pos;
        int bi;
        if (left == 0) return 1'b1;
        pos = FRAME - left;
        bi  = pos / CPB;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return logic'((cur >> (bi - 1)) & 1);
        return 1'b1;
    endfunction

    task automatic check_all(input string ph);
        chk({ph, ".tx"},         32'(bus.tx),         32'(model_tx()));
        chk({ph, ".busy"},       32'(bus.busy),       32'(left > 0));
        chk({ph, ".fifo_count"}, 32'(bus.fifo_count), 32'(mq.size()));
        chk({ph, ".fifo_full"},  32'(bus.fifo_full),  32'(mq.size() == DEPTH));
        chk({ph, ".fifo_empty"}, 32'(bus.fifo_empty), 32'(mq.size() == 0));
        chk({ph, ".overflow"},   32'(bus.overflow),   32'(movf));
    endtask

    // One clock: check the state left by the previous edge, then drive the
    // inputs for the next edge and advance the model across it.
    task automatic step(input string ph, input bit v, input logic [7:0] d, input bit c);
        @(negedge clk);
        hist_tx.push_back(int'(bus.tx));
        hist_busy.push_back(int'(bus.busy));
        if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
        check_all(ph);
        bus.ascii_valid = v;
        bus.ascii_in    = d;
        bus.clr         = c;
        model_edge(v, d, c);
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_line_idle(input string ph);
        int i;
        for (i = 0; i < 400; i++) begin
            if (left == 0 && mq.size() == 0) break;
            step(ph, 1'b0, 8'h00, 1'b0);
        end
        if (i == 400) chk({ph, ".idle_timeout"}, 32'd0, 32'd1);
        idle(ph, 2);
    endtask

    int pat[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

    initial begin
        int busy_cycles;
        int i;
        logic [7:0] d;
        bit v;
        bit c;

        rst             = 1'b1;
        bus.ascii_valid = 1'b0;
        bus.ascii_in    = 8'h00;
        bus.clr         = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.tx",         32'(bus.tx),         32'd1);
        chk("reset.busy",       32'(bus.busy),       32'd0);
        chk("reset.fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("reset.fifo_empty", 32'(bus.fifo_empty), 32'd1);
        chk("reset.fifo_full",  32'(bus.fifo_full),  32'd0);
        chk("reset.overflow",   32'(bus.overflow),   32'd0);
        rst = 1'b0;

        // Single 'A' frame: sample each bit in the middle of its cell.
        hist_tx.delete();
        hist_busy.delete();
        step("a_frame", 1'b1, 8'h41, 1'b0);
        idle("a_frame", 44);
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("a_frame.bit%0d", b), 32'(hist_tx[2 + CPB * b + 2]), 32'(pat[b]));
        end
        busy_cycles = 0;
        foreach (hist_busy[k]) busy_cycles += hist_busy[k];
        chk("a_frame.busy_cycles", 32'(busy_cycles), 32'(FRAME));
        chk("a_frame.end_empty", 32'(bus.fifo_empty), 32'd1);

        // "SOS" on consecutive cycles.
        peak = 0;
        step("sos", 1'b1, 8'h53, 1'b0);
        step("sos", 1'b1, 8'h4F, 1'b0);
        step("sos", 1'b1, 8'h53, 1'b0);
        wait_line_idle("sos");
        chk("sos.peak_count", 32'(peak), 32'd2);

        // Overflow: six writes back to back, then a flush mid-frame.
        for (int k = 0; k < 6; k++) step("ovf", 1'b1, 8'(8'h61 + k), 1'b0);
        idle("ovf", 1);
        chk("ovf.full",     32'(bus.fifo_full), 32'd1);
        chk("ovf.overflow", 32'(bus.overflow),  32'd1);
        idle("ovf", 7);
        step("ovf_clr", 1'b0, 8'h00, 1'b1);
        idle("ovf_clr", 1);
        chk("ovf_clr.overflow",   32'(bus.overflow),   32'd0);
        chk("ovf_clr.fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("ovf_clr.busy",       32'(bus.busy),       32'd1);
        wait_line_idle("ovf_clr");

        // Full queue plus a write on the exact STOP->START pop edge.
        for (int k = 0; k < 5; k++) step("fullpop", 1'b1, 8'(8'h30 + k), 1'b0);
        for (i = 0; i < 100; i++) begin
            if (left == 1) break;
            step("fullpop", 1'b0, 8'h00, 1'b0);
        end
        if (i == 100) chk("fullpop.timeout", 32'd0, 32'd1);
        chk("fullpop.pre_full", 32'(bus.fifo_full), 32'd1);
        step("fullpop", 1'b1, 8'h39, 1'b0);
        idle("fullpop", 1);
        chk("fullpop.count",    32'(bus.fifo_count), 32'd4);
        chk("fullpop.overflow", 32'(bus.overflow),   32'd0);
        wait_line_idle("fullpop");

        // Null code is ignored.
        step("null", 1'b1, 8'h00, 1'b0);
        idle("null", 1);
        chk("null.count",    32'(bus.fifo_count), 32'd0);
        chk("null.overflow", 32'(bus.overflow),   32'd0);
        chk("null.tx",       32'(bus.tx),         32'd1);
        idle("null", 3);

        // Asynchronous reset in the middle of the data bits.
        step("arst", 1'b1, 8'h5A, 1'b0);
        idle("arst", 15);
        @(negedge clk);
        bus.ascii_valid = 1'b0;
        bus.ascii_in    = 8'h00;
        bus.clr         = 1'b0;
        chk("arst.pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst.tx",   32'(bus.tx),   32'd1);
        chk("arst.busy", 32'(bus.busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step("arst_e", 1'b1, 8'h45, 1'b0);
        wait_line_idle("arst_e");

        // Randomized traffic, alternating heavy and light write rates.
        for (int seg = 0; seg < 6; seg++) begin
            for (int k = 0; k < 300; k++) begin
                if (seg % 2 == 0) v = ($urandom_range(0, 3) == 0);
                else              v = ($urandom_range(0, 59) == 0);
                d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                c = ($urandom_range(0, 249) == 0);
                step("rand", v, d, c);
            end
        end
        wait_line_idle("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
